// File: rtl/thd_harmonic_engine.sv
// ============================================================================
// Module  : thd_harmonic_engine
// Brief   : Buffers one magnitude frame, finds the peak bin and sums squared
//           harmonic magnitudes. Optional macro: THD_DC_SKIP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module thd_harmonic_engine #(
  parameter int DATA_W    = 12,
  parameter int ADDR_W    = 10,
  parameter int NUM_HARM  = 5,
  parameter int ACC_W     = 2*DATA_W+4,
  parameter int SKIP_BINS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] fund_bin,
  output logic [DATA_W-1:0] fund_mag,
  output logic [ACC_W-1:0]  harm_sq_sum,
  output logic              sum_sat
);

`ifdef THD_DC_SKIP_EN
  localparam int SEARCH_START = SKIP_BINS;
`else
  // Only DC is excluded; SKIP_BINS is carried for a uniform parameter list.
  localparam int SEARCH_START = 1 + 0 * SKIP_BINS;
`endif

  localparam int                HALF      = 2 ** (ADDR_W - 1);
  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(HALF - 1);
  localparam logic [ADDR_W-1:0] START_BIN = ADDR_W'(SEARCH_START);
  localparam logic [3:0]        K_LAST    = 4'(NUM_HARM);
  localparam int                SUM_W     = ((ACC_W > 2*DATA_W) ? ACC_W : 2*DATA_W) + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_SFLUSH = 3'd2,
    ST_HARM   = 3'd3,
    ST_HFLUSH = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic [DATA_W-1:0]   rd_data_q;
  logic [ADDR_W-1:0]   rd_addr;
  logic                wr_en;
  logic                frame_start;

  logic [ADDR_W-1:0]   srch_addr_q;
  logic [ADDR_W-1:0]   srch_tag_q;
  logic                srch_vld_q;
  logic [ADDR_W-1:0]   best_bin_q;
  logic [DATA_W-1:0]   best_mag_q;

  logic [3:0]          k_q;
  logic [ADDR_W+3:0]   harm_prod;
  logic                harm_in_range;
  logic                harm_vld_q;
  logic                hflush_q;

  logic [2*DATA_W-1:0] sq_d, sq_q;
  logic [SUM_W-1:0]    sum_wide;
  logic                sum_ovf;
  logic [ACC_W-1:0]    acc_d, acc_q;
  logic                sat_d, sat_q;

  assign wr_en       = (state_q == ST_IDLE) && in_valid;
  assign frame_start = wr_en && in_last;

  assign harm_prod     = (ADDR_W+4)'(k_q) * (ADDR_W+4)'(best_bin_q);
  assign harm_in_range = harm_prod < (ADDR_W+4)'(HALF);
  assign rd_addr       = (state_q == ST_HARM) ? harm_prod[ADDR_W-1:0] : srch_addr_q;

  // Spectrum store: no reset so it maps onto block RAM with a registered read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[in_addr] <= in_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (frame_start) state_d = ST_SEARCH;
      ST_SEARCH: if (srch_addr_q == LAST_BIN) state_d = ST_SFLUSH;
      ST_SFLUSH: state_d = ST_HARM;
      ST_HARM:   if (k_q == K_LAST) state_d = ST_HFLUSH;
      ST_HFLUSH: if (hflush_q) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Peak search: the compare runs one cycle behind the read it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srch_addr_q <= '0;
      srch_tag_q  <= '0;
      srch_vld_q  <= 1'b0;
      best_bin_q  <= '0;
      best_mag_q  <= '0;
    end else begin
      srch_vld_q <= (state_q == ST_SEARCH);
      srch_tag_q <= srch_addr_q;
      if (frame_start) begin
        srch_addr_q <= START_BIN;
        best_bin_q  <= START_BIN;
        best_mag_q  <= '0;
      end else begin
        if (state_q == ST_SEARCH) begin
          srch_addr_q <= srch_addr_q + 1'b1;
        end
        if (srch_vld_q && (rd_data_q > best_mag_q)) begin
          best_bin_q <= srch_tag_q;
          best_mag_q <= rd_data_q;
        end
      end
    end
  end

  assign sq_d = {{DATA_W{1'b0}}, rd_data_q} * {{DATA_W{1'b0}}, rd_data_q};

  // Out-of-range harmonics never raise harm_vld_q, so they contribute zero.
  assign sum_wide = SUM_W'(acc_q) + SUM_W'(sq_q);
  assign sum_ovf  = |sum_wide[SUM_W-1:ACC_W];
  assign acc_d    = sum_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign sat_d    = sat_q | sum_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q        <= '0;
      harm_vld_q <= 1'b0;
      hflush_q   <= 1'b0;
      sq_q       <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      harm_vld_q <= (state_q == ST_HARM) && harm_in_range;
      hflush_q   <= (state_q == ST_HFLUSH) && !hflush_q;
      sq_q       <= harm_vld_q ? sq_d : '0;
      if (state_q == ST_SFLUSH) begin
        k_q <= 4'd2;
      end else if (state_q == ST_HARM) begin
        k_q <= k_q + 4'd1;
      end
      if (frame_start) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end else if ((state_q == ST_HARM) || (state_q == ST_HFLUSH)) begin
        acc_q <= acc_d;
        sat_q <= sat_d;
      end
    end
  end

  // Results are captured on the edge into DONE so they are valid with done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fund_bin    <= '0;
      fund_mag    <= '0;
      harm_sq_sum <= '0;
      sum_sat     <= 1'b0;
    end else if ((state_q == ST_HFLUSH) && hflush_q) begin
      fund_bin    <= best_bin_q;
      fund_mag    <= best_mag_q;
      harm_sq_sum <= acc_d;
      sum_sat     <= sat_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_thd_harmonic_engine.sv
// Directed bench for thd_harmonic_engine: default instance plus an ACC_W=8
// instance sharing the same stimulus to exercise saturation.
`default_nettype none

module tb_thd_harmonic_engine;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 10;
  localparam int NFFT   = 1024;
`ifdef THD_DC_SKIP_EN
  localparam int S = 4;
`else
  localparam int S = 1;
`endif
  localparam int LAT = (NFFT/2 - S) + 5 + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic              in_valid;
  logic              in_last;

  logic              busy, done, sum_sat;
  logic [ADDR_W-1:0] fund_bin;
  logic [DATA_W-1:0] fund_mag;
  logic [27:0]       harm_sq_sum;

  logic              s_busy, s_done, s_sum_sat;
  logic [ADDR_W-1:0] s_fund_bin;
  logic [DATA_W-1:0] s_fund_mag;
  logic [7:0]        s_harm_sq_sum;

  logic [DATA_W-1:0] spec [NFFT];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  thd_harmonic_engine dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_addr(in_addr),
    .in_valid(in_valid), .in_last(in_last), .busy(busy), .done(done),
    .fund_bin(fund_bin), .fund_mag(fund_mag), .harm_sq_sum(harm_sq_sum),
    .sum_sat(sum_sat)
  );

  thd_harmonic_engine #(.ACC_W(8)) dut_sat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_addr(in_addr),
    .in_valid(in_valid), .in_last(in_last), .busy(s_busy), .done(s_done),
    .fund_bin(s_fund_bin), .fund_mag(s_fund_mag), .harm_sq_sum(s_harm_sq_sum),
    .sum_sat(s_sum_sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_spec();
    for (int i = 0; i < NFFT; i++) spec[i] = '0;
  endtask

  task automatic send_frame();
    for (int a = 0; a < NFFT; a++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_addr  = ADDR_W'(a);
      in_data  = spec[a];
      in_last  = (a == NFFT - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Optionally drives writes/in_last while busy; they must be ignored.
  task automatic wait_done(input bit junk, output int lat);
    lat = 0;
    for (int c = 1; c <= 3000; c++) begin
      if (junk && c <= 50) begin
        in_valid = 1'b1; in_addr = 10'd10; in_data = 12'd5; in_last = 1'b1;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit junk, input int eb, input int em,
                           input int es, input int esat, input int ss, input int ssat);
    int lat;
    send_frame();
    check({tag, "_busy"}, busy, 1);
    wait_done(junk, lat);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_fund_bin"}, fund_bin, eb);
    check({tag, "_fund_mag"}, fund_mag, em);
    check({tag, "_sum"}, harm_sq_sum, es);
    check({tag, "_sat"}, sum_sat, esat);
    check({tag, "_s_sum"}, s_harm_sq_sum, ss);
    check({tag, "_s_sat"}, s_sum_sat, ssat);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold_bin"}, fund_bin, eb);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_addr = '0; in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fund_bin", fund_bin, 0);
    check("rst_fund_mag", fund_mag, 0);
    check("rst_sum", harm_sq_sum, 0);
    check("rst_sat", sum_sat, 0);
    rst = 1'b1;
    @(negedge clk);

    // 100^2 + 50^2 = 12500; exceeds 255 in the narrow instance
    clear_spec(); spec[10] = 1000; spec[20] = 100; spec[30] = 50;
    run_frame("basic", 1'b1, 10, 1000, 12500, 0, 255, 1);

    clear_spec(); spec[12] = 800; spec[40] = 800;
    run_frame("tie", 1'b0, 12, 800, 0, 0, 0, 0);

    clear_spec();
    run_frame("zero", 1'b0, S, 0, 0, 0, 0, 0);

    clear_spec(); spec[2] = 4000; spec[50] = 900;
    run_frame("skip", 1'b0, (S == 4) ? 50 : 2, (S == 4) ? 900 : 4000, 0, 0, 0, 0);

    // k=3 -> 600 (>=512) must not read bin 600 nor alias to bin 88
    clear_spec(); spec[200] = 1000; spec[400] = 300; spec[88] = 500; spec[600] = 4000;
    run_frame("range", 1'b0, 200, 1000, 90000, 0, 255, 1);

    // 4 * 4095^2 = 67076100
    clear_spec(); for (int k = 1; k <= 5; k++) spec[10*k] = 4095;
    run_frame("sat", 1'b0, 10, 4095, 67076100, 0, 255, 1);

    clear_spec(); spec[10] = 1000; spec[20] = 100; spec[30] = 50;
    send_frame();
    repeat (99) @(negedge clk);
    check("abort_busy_pre", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_fund_bin", fund_bin, 0);
    check("abort_fund_mag", fund_mag, 0);
    check("abort_sum", harm_sq_sum, 0);
    check("abort_s_sat", s_sum_sat, 0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);

    run_frame("after_abort", 1'b0, 10, 1000, 12500, 0, 255, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
